uart_rx: RTL and testbench
==========================

# uart_rx

Receive stage of the thermometer's serial link. It sits directly downstream of `baud_rate_generator` and consumes its single-cycle `sample_tick`, which runs at 16× the line baud rate. The block oversamples the asynchronous `rx` line, detects and qualifies a start bit, and shifts in an 8N1 frame LSB-first. Each completed byte is presented with a one-cycle `rx_done_tick` plus a framing-error flag for the command/readout logic.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame (legal 5–8).
- `SB_TICK`, 16: sample ticks spanning the stop bit (16 = 1 stop bit, 32 = 2).
- `OS`, 16: oversampling ratio; must be even, fixed at 16 in this design.

Ports:
- `clk` input 1: system clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state when 0.
- `sample_tick` input 1: one-clk pulse from `baud_rate_generator`, 16 per bit period.
- `rx` input 1: asynchronous serial line, idle high.
- `dout` output DBIT: last received byte; holds until the next frame completes.
- `rx_done_tick` output 1: one-clk pulse, asserted in the cycle `dout` updates.
- `frame_err` output 1: stop-bit value was 0 for the frame just completed; valid with `rx_done_tick`, held until the next done.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM sees only `rx_s`.
- Internal registers:
  - `s`: tick counter, 4 bits, wide enough for `SB_TICK-1`.
  - `n`: bit counter, 3 bits.
  - `b`: shift register, DBIT wide.
- The FSM has four states: IDLE, START, DATA, STOP.
- IDLE:
  - If `rx_s` == 0, go to START and set `s` = 0.
  - No tick is required to leave IDLE.
- START, on each `sample_tick`:
  - If `s` == OS/2−1 (7) and `rx_s` == 0, go to DATA with `s` = 0 and `n` = 0.
  - If `s` == 7 and `rx_s` == 1, treat it as a glitch and return to IDLE with no done pulse.
  - Otherwise `s` increments.
- DATA, on each `sample_tick`:
  - When `s` == 15, set `s` = 0 and shift `b` = {`rx_s`, `b[DBIT-1:1]`} (LSB first).
  - If `n` == DBIT−1, go to STOP; else `n` increments.
  - Otherwise `s` increments.
- STOP, on each `sample_tick`:
  - When `s` == SB_TICK−1, load `dout` ← `b` and `frame_err` ← ~`rx_s`, pulse `rx_done_tick`, and go to IDLE.
  - Otherwise `s` increments.
- `sample_tick` low freezes all counters; the FSM advances only on ticks, except for the IDLE exit.
- A framing error still delivers the byte; a downstream consumer decides whether to discard it.
- The line stuck low after a frame produces a back-to-back start detection, which is accepted.

## Timing
- Reset values: state = IDLE; `s`, `n`, `b`, `dout` = 0; `rx_done_tick` = 0; `frame_err` = 0; `busy` = 0; synchronizer flops = 1 (idle line).
- Input latency: 2 clk from an `rx` edge to `rx_s`.
- Sample points: every bit is sampled at tick 7 of the start bit, then every 16 ticks after that, i.e. mid-bit.
- Frame length: from start detection to `rx_done_tick` takes 8 + 16·DBIT + SB_TICK ticks, i.e. 152 ticks for the defaults.
- `rx_done_tick` is exactly one clk wide and coincides with the `dout` update; `busy` falls on the following clk.
- Reset mid-frame aborts immediately: the FSM returns to IDLE, no done pulse is generated, and `dout` is cleared.
- Simultaneous events: a tick arriving in the same cycle IDLE sees `rx_s` = 0 is not counted; counting starts on the next tick.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`.
  - Constants `UART_DBIT` = 8, `UART_OS` = 16, `UART_SB_TICK` = 16.
  - Shared later by `uart_tx`.
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with a reset value parameter, instantiated for `rx` with reset value 1.

## Test plan
Common setup: the bench drives `sample_tick` every 5 clk (generator at dvsr = 4), so one bit = 80 clk.
- Byte 0xA5, valid stop: `rx_done_tick` pulses exactly once, `dout` = 8'hA5, `frame_err` = 0, pulse 152 ticks after start detection (±2 clk for the synchronizer).
- Byte 0x3C with the stop bit driven 0: `dout` = 8'h3C, `frame_err` = 1; a following valid 0xFF clears `frame_err` to 0.
- Start glitch, `rx` low for 3 ticks then high: FSM returns to IDLE at tick 7, no `rx_done_tick`, `dout` unchanged.
- Back-to-back frames 0x00 then 0xFF with no idle gap: two done pulses, `dout` = 8'h00 then 8'hFF.
- Reset asserted (0) during DATA bit 4 of 0x55: `busy` = 0 and `dout` = 0 immediately, no done pulse; a subsequent 0x55 is received correctly.
- `sample_tick` held low for 200 clk mid-DATA: state, `s` and `n` are frozen; the frame completes correctly once ticks resume.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame constants
// and a helper that sizes the oversample tick counter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int UART_DBIT    = 8;
    localparam int UART_OS      = 16;
    localparam int UART_SB_TICK = 16;

    // Tick counter must reach both OS-1 (data bits) and SB_TICK-1 (stop span).
    function automatic int tick_cnt_w(input int sb_tick, input int os);
        int w_sb;
        int w_os;
        w_sb = $clog2(sb_tick);
        w_os = $clog2(os);
        return (w_sb > w_os) ? w_sb : w_os;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; the reset
// value lets an idle-high line come out of reset without a false edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: qualifies the start bit at mid-bit, shifts
// data LSB-first on sample_tick, and reports each byte with a framing flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int OS      = UART_OS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = tick_cnt_w(SB_TICK, OS);

    localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

    logic            w_rx_s;
    rx_state_t       r_state;
    logic [SW-1:0]   r_s;
    logic [2:0]      r_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // Leaving IDLE needs no tick; a coincident tick is deliberately ignored.
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_s     <= '0;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (r_s == S_MID) begin
                            if (!w_rx_s) begin
                                r_state <= DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        if (r_s == S_BIT) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        if (r_s == S_STOP) begin
                            r_dout  <= r_b;
                            r_ferr  <= ~w_rx_s;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
    // Held through the done cycle so busy drops on the clk after the pulse.
    assign busy         = (r_state != IDLE) | r_done;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are built bit-by-bit on a tick grid and
// each expected byte/flag/latency is queued and matched when the done pulse arrives.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick = 1'b0;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    uart_rx #(.DBIT(8), .SB_TICK(16), .OS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          errs   = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Tick generator: one pulse every 5 clk while enabled; the phase holds when disabled.
    bit tick_en = 1'b0;
    int tcnt    = 0;
    always @(posedge clk) begin
        cyc++;
        if (!tick_en) begin
            sample_tick <= 1'b0;
        end else if (tcnt == 4) begin
            tcnt        <= 0;
            sample_tick <= 1'b1;
        end else begin
            tcnt        <= tcnt + 1;
            sample_tick <= 1'b0;
        end
    end

    typedef struct {
        logic [7:0]  data;
        logic        ferr;
        int unsigned t0;
        bit          lat;
    } exp_t;

    exp_t       expq[$];
    exp_t       mon_e;
    int         n_done    = 0;
    int         n_exp     = 0;
    logic [7:0] last_dout = 8'h00;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    int         lat_d;

    always @(negedge clk) begin
        if (prev_done) begin
            chk("done_width", rx_done_tick, 1'b0);
            if (!prev_ferr) chk("busy_fall", busy, 1'b0);
        end
        if (rx_done_tick === 1'b1) begin
            n_done++;
            if (expq.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                chk("dout", dout, mon_e.data);
                chk("frame_err", frame_err, mon_e.ferr);
                chk("busy_at_done", busy, 1'b1);
                if (mon_e.lat) begin
                    // 152 ticks * 5 clk from the start edge, small slack for sync
                    lat_d = int'(cyc - mon_e.t0);
                    chk("latency_clk", (lat_d >= 758 && lat_d <= 762) ? 760 : lat_d, 760);
                end
                prev_ferr = mon_e.ferr;
            end
        end
        prev_done = rx_done_tick;
    end

    // Waits n sample ticks, returning 1 time unit after the tick edge.
    task automatic wait_ticks(input int n);
        int g;
        repeat (n) begin
            g = 0;
            do begin
                @(posedge clk);
                g++;
            end while (!sample_tick && g < 100);
            if (g >= 100) chk("tick_timeout", 0, 1);
            #1;
        end
    endtask

    // abort_bit >= 0: reset mid-bit; freeze_bit >= 0: stall ticks for 200 clk mid-bit.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                              input int abort_bit, input int freeze_bit);
        exp_t e;
        int   nd0;
        e.data = data;
        e.ferr = !stop_ok;
        e.t0   = cyc;
        e.lat  = (freeze_bit < 0);
        expq.push_back(e);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == abort_bit) begin
                wait_ticks(8);
                reset = 1'b0;
                #1;
                chk("abort_busy", busy, 1'b0);
                chk("abort_dout", dout, 8'h00);
                chk("abort_done", rx_done_tick, 1'b0);
                void'(expq.pop_back());
                last_dout = 8'h00;
                rx = 1'b1;
                repeat (3) @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
            if (i == freeze_bit) begin
                wait_ticks(4);
                tick_en = 1'b0;
                nd0 = n_done;
                repeat (200) @(posedge clk);
                #1;
                chk("freeze_busy", busy, 1'b1);
                chk("freeze_no_done", n_done, nd0);
                tick_en = 1'b1;
                wait_ticks(12);
            end else begin
                wait_ticks(16);
            end
        end
        rx = stop_ok;
        if (stop_ok) begin
            wait_ticks(16);
        end else begin
            // Bad stop is held only past its sample point so no real start follows.
            wait_ticks(10);
            rx = 1'b1;
            wait_ticks(6);
        end
        n_exp++;
        last_dout = data;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         ok;
        int         gap;
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_done", rx_done_tick, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset   = 1'b1;
        tick_en = 1'b1;
        wait_ticks(20);
        chk("idle_busy", busy, 1'b0);

        send_frame(8'hA5, 1'b1, -1, -1);
        wait_ticks(16);

        send_frame(8'h3C, 1'b0, -1, -1);
        wait_ticks(32);
        send_frame(8'hFF, 1'b1, -1, -1);
        wait_ticks(16);

        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(16);
        chk("glitch_busy", busy, 1'b0);
        chk("glitch_dout", dout, last_dout);
        chk("glitch_no_done", n_done, n_exp);

        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        wait_ticks(16);

        send_frame(8'h55, 1'b1, 4, -1);
        wait_ticks(16);
        chk("post_abort_dout", dout, 8'h00);
        send_frame(8'h55, 1'b1, -1, -1);
        wait_ticks(16);

        send_frame(8'h96, 1'b1, -1, 3);
        wait_ticks(16);

        for (int k = 0; k < 12; k++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 3) != 0);
            gap = int'($urandom_range(0, 20));
            send_frame(d, ok, -1, -1);
            wait_ticks(gap);
        end
        wait_ticks(32);
        chk("queue_empty", expq.size(), 0);
        chk("done_count", n_done, n_exp);
        chk("final_dout", dout, last_dout);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
